// File: rtl/lfsr_rand_range_if.sv
// Control/response bundle for lfsr_rand_range: LFSR controls, ranged-value request and raw state.
interface lfsr_rand_range_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned OUT_W = 10
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             req;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] rnd;
  logic [WIDTH-1:0] state;

  modport master (
    output en, load, seed_in, req,
    input  busy, valid, rnd, state
  );

  modport slave (
    input  en, load, seed_in, req,
    output busy, valid, rnd, state
  );
endinterface

// File: rtl/lfsr_rand_range.sv
// Galois LFSR random source with a ranged request port reduced by repeated subtraction.
// Optional macro RAND_DEBRUIJN_EN: include the all-zero state in the sequence (period 2^WIDTH).
module lfsr_rand_range #(
  parameter int unsigned     WIDTH  = 9,
  parameter logic [WIDTH-1:0] TAPS  = 9'h011,
  parameter logic [WIDTH-1:0] SEED  = 9'd123,
  parameter int unsigned     RANGE  = 100,
  parameter int unsigned     OFFSET = 0,
  parameter int unsigned     OUT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_rand_range_if.slave  bus
);

  localparam int unsigned      CW       = WIDTH + 1;
  localparam logic [CW-1:0]    RANGE_C  = CW'(RANGE);
  localparam logic [WIDTH-1:0] RANGE_W  = WIDTH'(RANGE);
  localparam logic [OUT_W-1:0] OFFSET_C = OUT_W'(OFFSET);

  typedef enum logic {IDLE, REDUCE} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             fb_c;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] seed_c;

  // LFSR next state; load has priority over en
  always_comb begin
`ifdef RAND_DEBRUIJN_EN
    fb_c   = lfsr_q[WIDTH-1] ^ ~|lfsr_q[WIDTH-2:0];
    step_c = (lfsr_q << 1) ^ (fb_c ? TAPS : '0);
    seed_c = bus.seed_in;
`else
    fb_c   = lfsr_q[WIDTH-1];
    step_c = (lfsr_q == '0) ? SEED : ((lfsr_q << 1) ^ (fb_c ? TAPS : '0));
    seed_c = (bus.seed_in == '0) ? SEED : bus.seed_in;
`endif
    lfsr_d = lfsr_q;
    if (bus.load) begin
      lfsr_d = seed_c;
    end else if (bus.en) begin
      lfsr_d = step_c;
    end
  end

  // Request FSM: capture the pre-edge state, then subtract RANGE until it fits
  always_comb begin
    fsm_d   = fsm_q;
    r_d     = r_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    rnd_d   = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (bus.req) begin
          r_d    = lfsr_q;
          busy_d = 1'b1;
          fsm_d  = REDUCE;
        end
      end
      REDUCE: begin
        if ({1'b0, r_q} >= RANGE_C) begin
          r_d = r_q - RANGE_W;
        end else begin
          rnd_d   = OUT_W'(r_q) + OFFSET_C;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          fsm_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      lfsr_q  <= SEED;
      r_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rnd_q   <= rnd_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.rnd   = rnd_q;
  assign bus.state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Bench for lfsr_rand_range: three configurations share one stimulus and one arithmetic model.
module tb_lfsr_rand_range;
  localparam int unsigned WIDTH = 9;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned SEED  = 123;
  localparam int unsigned TAPS  = 32'h011;
  localparam int unsigned NI    = 3;

  function automatic int unsigned cfg_range(input int i);
    return (i == 2) ? 512 : 100;
  endfunction

  function automatic int unsigned cfg_off(input int i);
    case (i)
      0:       return 0;
      1:       return 20;
      default: return 5;
    endcase
  endfunction

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic             req = 1'b0;
  logic [WIDTH-1:0] seed_in = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_rand_range_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus0 ();
  lfsr_rand_range_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus1 ();
  lfsr_rand_range_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus2 ();

  assign bus0.en = en;  assign bus0.load = load;  assign bus0.seed_in = seed_in;  assign bus0.req = req;
  assign bus1.en = en;  assign bus1.load = load;  assign bus1.seed_in = seed_in;  assign bus1.req = req;
  assign bus2.en = en;  assign bus2.load = load;  assign bus2.seed_in = seed_in;  assign bus2.req = req;

  lfsr_rand_range #(.WIDTH(9), .TAPS(9'h011), .SEED(9'd123), .RANGE(100), .OFFSET(0), .OUT_W(10))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lfsr_rand_range #(.WIDTH(9), .TAPS(9'h011), .SEED(9'd123), .RANGE(100), .OFFSET(20), .OUT_W(10))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  lfsr_rand_range #(.WIDTH(9), .TAPS(9'h011), .SEED(9'd123), .RANGE(512), .OFFSET(5), .OUT_W(10))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic             busy_o  [NI];
  logic             valid_o [NI];
  logic [OUT_W-1:0] rnd_o   [NI];
  logic [WIDTH-1:0] state_o [NI];

  assign busy_o[0] = bus0.busy;  assign valid_o[0] = bus0.valid;  assign rnd_o[0] = bus0.rnd;  assign state_o[0] = bus0.state;
  assign busy_o[1] = bus1.busy;  assign valid_o[1] = bus1.valid;  assign rnd_o[1] = bus1.rnd;  assign state_o[1] = bus1.state;
  assign busy_o[2] = bus2.busy;  assign valid_o[2] = bus2.valid;  assign rnd_o[2] = bus2.rnd;  assign state_o[2] = bus2.state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: LFSR as polynomial arithmetic, reduction as quotient/remainder with a latency countdown
  int unsigned st_m;
  bit          busy_m  [NI];
  bit          valid_m [NI];
  int unsigned rnd_m   [NI];
  int unsigned res_m   [NI];
  int unsigned rem_m   [NI];
  bit          model_on = 1'b0;

  function automatic int unsigned step_m(input int unsigned s);
`ifdef RAND_DEBRUIJN_EN
    bit fb;
    fb = (s >= 256) != ((s % 256) == 0);
    return ((s * 2) % 512) ^ (fb ? TAPS : 0);
`else
    if (s == 0) return SEED;
    return (s >= 256) ? (((s * 2) % 512) ^ TAPS) : (s * 2);
`endif
  endfunction

  function automatic int unsigned load_m(input int unsigned s);
`ifdef RAND_DEBRUIJN_EN
    return s;
`else
    return (s == 0) ? SEED : s;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      st_m = SEED;
      for (int i = 0; i < NI; i++) begin
        busy_m[i] = 1'b0; valid_m[i] = 1'b0; rnd_m[i] = 0; rem_m[i] = 0; res_m[i] = 0;
      end
      model_on = 1'b1;
    end else begin
      for (int i = 0; i < NI; i++) begin
        valid_m[i] = 1'b0;
        if (busy_m[i]) begin
          if (rem_m[i] == 0) begin
            valid_m[i] = 1'b1; busy_m[i] = 1'b0; rnd_m[i] = res_m[i];
          end else begin
            rem_m[i] = rem_m[i] - 1;
          end
        end else if (req) begin
          busy_m[i] = 1'b1;
          rem_m[i]  = st_m / cfg_range(i);
          res_m[i]  = st_m % cfg_range(i) + cfg_off(i);
        end
      end
      if (load) st_m = load_m(seed_in);
      else if (en) st_m = step_m(st_m);
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("state%0d", i), 32'(state_o[i]), st_m);
        check($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(busy_m[i]));
        check($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(valid_m[i]));
        check($sformatf("rnd%0d", i),   32'(rnd_o[i]),   rnd_m[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count edges after the accept edge until instance idx pulses valid
  task automatic wait_valid(input int idx, input int max, output int n);
    for (n = 1; n <= max; n++) begin
      tick();
      if (valid_o[idx] === 1'b1) break;
    end
  endtask

  initial begin
    int n;
    int cnt;
    int zeros;

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_state", 32'(state_o[i]), 32'h07B);
      check("reset_busy",  32'(busy_o[i]),  0);
      check("reset_valid", 32'(valid_o[i]), 0);
      check("reset_rnd",   32'(rnd_o[i]),   0);
    end
    rst = 1'b0;

    en = 1'b1;
    tick(); check("step1", 32'(state_o[0]), 32'h0F6);
    tick(); check("step2", 32'(state_o[0]), 32'h1EC);
    tick(); check("step3", 32'(state_o[0]), 32'h1C9);
    en = 1'b0;

    // 246 with RANGE 100: two subtractions
    load = 1'b1; seed_in = 9'h0F6; tick(); load = 1'b0;
    check("load_f6", 32'(state_o[0]), 32'h0F6);
    req = 1'b1; tick(); req = 1'b0;
    check("busy_acc", 32'(busy_o[0]), 1);
    wait_valid(0, 10, n);
    check("lat_246", n, 3);
    check("rnd_246", 32'(rnd_o[0]), 46);
    check("rnd_246_off", 32'(rnd_o[1]), 66);
    check("busy_done", 32'(busy_o[0]), 0);

    // 123 with OFFSET 20: one subtraction
    load = 1'b1; seed_in = 9'h07B; tick(); load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    wait_valid(1, 10, n);
    check("lat_123", n, 2);
    check("rnd_123_off", 32'(rnd_o[1]), 43);
    check("rnd_123", 32'(rnd_o[0]), 23);

    load = 1'b1; seed_in = '0; tick(); load = 1'b0;
`ifdef RAND_DEBRUIJN_EN
    check("load_zero", 32'(state_o[0]), 0);
    en = 1'b1; tick(); en = 1'b0;
`else
    check("load_zero", 32'(state_o[0]), 123);
`endif

    // Reset in the middle of a long reduction
    load = 1'b1; seed_in = 9'h1FF; tick(); load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy",  32'(busy_o[0]),  0);
    check("rst_valid", 32'(valid_o[0]), 0);
    check("rst_rnd",   32'(rnd_o[0]),   0);
    check("rst_state", 32'(state_o[0]), 123);
    repeat (6) begin
      tick();
      check("rst_no_valid", 32'(valid_o[0]), 0);
    end
    req = 1'b1; tick(); req = 1'b0;
    wait_valid(0, 10, n);
    check("lat_after_rst", n, 2);
    check("rnd_after_rst", 32'(rnd_o[0]), 23);

    // Held request while the LFSR free-runs
    en = 1'b1; req = 1'b1;
    repeat (60) tick();
    en = 1'b0; req = 1'b0;
    repeat (8) tick();

    // Full period from SEED
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; cnt = 0; zeros = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      cnt++;
      if (state_o[0] == '0) zeros++;
      if (state_o[0] == 9'd123) break;
    end
    en = 1'b0;
`ifdef RAND_DEBRUIJN_EN
    check("period", cnt, 512);
    check("zero_visits", zeros, 1);
`else
    check("period", cnt, 511);
    check("zero_visits", zeros, 0);
`endif

    // Mixed deterministic pattern of en/load/req, including load with req
    for (int i = 0; i < 300; i++) begin
      en      = (i % 3) != 0;
      load    = (i % 37) == 5 || (i % 53) == 0;
      seed_in = WIDTH'((i * 73) % 512);
      req     = (i % 7) < 3;
      tick();
    end
    en = 1'b0; load = 1'b0; req = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
